// File: rtl/pcileech_tlps128_source_demux.sv
// pcileech_tlps128_source_demux: steers whole 128-bit TLPs from the PCIe core to one of four sink streams.
module pcileech_tlps128_source_demux #(
    parameter bit DROP_OTHER = 1'b1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk_pcie,
    input  logic                 rst,
    input  logic [3:0]           port_en,
    input  logic [127:0]         in_tdata,
    input  logic [3:0]           in_tkeepdw,
    input  logic [8:0]           in_tuser,
    input  logic                 in_tlast,
    input  logic                 in_tvalid,
    output logic                 in_tready,
    output logic [127:0]         out1_tdata,
    output logic [3:0]           out1_tkeepdw,
    output logic [8:0]           out1_tuser,
    output logic                 out1_tlast,
    output logic                 out1_tvalid,
    input  logic                 out1_tready,
    output logic                 out1_has_data,
    output logic [127:0]         out2_tdata,
    output logic [3:0]           out2_tkeepdw,
    output logic [8:0]           out2_tuser,
    output logic                 out2_tlast,
    output logic                 out2_tvalid,
    input  logic                 out2_tready,
    output logic                 out2_has_data,
    output logic [127:0]         out3_tdata,
    output logic [3:0]           out3_tkeepdw,
    output logic [8:0]           out3_tuser,
    output logic                 out3_tlast,
    output logic                 out3_tvalid,
    input  logic                 out3_tready,
    output logic                 out3_has_data,
    output logic [127:0]         out4_tdata,
    output logic [3:0]           out4_tkeepdw,
    output logic [8:0]           out4_tuser,
    output logic                 out4_tlast,
    output logic                 out4_tvalid,
    input  logic                 out4_tready,
    output logic                 out4_has_data,
    output logic [CNT_WIDTH-1:0] pkt_cnt1,
    output logic [CNT_WIDTH-1:0] pkt_cnt2,
    output logic [CNT_WIDTH-1:0] pkt_cnt3,
    output logic [CNT_WIDTH-1:0] pkt_cnt4,
    output logic [CNT_WIDTH-1:0] drop_cnt
);
    // Port routes encode their 0-based port index in the low two bits.
    typedef enum logic [2:0] {P1 = 3'd0, P2 = 3'd1, P3 = 3'd2, P4 = 3'd3, IDLE = 3'd4, DROP = 3'd5} route_t;

    route_t route, cls, eff;
    logic out_valid, out_tlast;
    logic [127:0] out_tdata;
    logic [3:0] out_tkeepdw;
    logic [8:0] out_tuser;
    logic [1:0] dest;
    logic [3:0] ready_v;
    logic [CNT_WIDTH-1:0] pkt_cnt [4];
    logic sel_ready, accept, fwd, is_cpl, is_cfg, is_mem;

    assign is_cpl    = in_tdata[31:25] == 7'b0000101 || in_tdata[31:25] == 7'b0100101;
    assign is_cfg    = in_tdata[31:25] == 7'b0000010 || in_tdata[31:25] == 7'b0100010;
    assign is_mem    = in_tdata[28:24] == 5'd0 && !in_tdata[31];
    assign ready_v   = {out4_tready, out3_tready, out2_tready, out1_tready};
    assign sel_ready = ready_v[dest];
    assign in_tready = !out_valid || sel_ready;
    assign accept    = in_tvalid && in_tready;
    assign fwd       = eff != DROP;

    always_comb begin
        cls = is_cpl ? (port_en[0] ? P1 : DROP) :
              is_cfg ? (port_en[1] ? P2 : DROP) :
              is_mem ? (port_en[2] ? P3 : DROP) :
              (!DROP_OTHER && port_en[3]) ? P4 : DROP;
        eff = in_tuser[0] ? cls : (route == IDLE ? DROP : route);
    end

    always_ff @(posedge clk_pcie) begin
        if (rst) begin
            out_valid <= 1'b0;
            route     <= IDLE;
            drop_cnt  <= '0;
            for (int i = 0; i < 4; i++) pkt_cnt[i] <= '0;
        end else begin
            if (accept && fwd)
                out_valid <= 1'b1;
            else if (sel_ready)
                out_valid <= 1'b0;
            if (accept)
                route <= in_tlast ? IDLE : eff;
            if (accept && !fwd && in_tlast && drop_cnt != '1)
                drop_cnt <= drop_cnt + 1'b1;
            for (int i = 0; i < 4; i++)
                if (out_valid && dest == 2'(i) && ready_v[i] && out_tlast && pkt_cnt[i] != '1)
                    pkt_cnt[i] <= pkt_cnt[i] + 1'b1;
        end
    end

    always_ff @(posedge clk_pcie) begin
        if (accept && fwd) begin
            out_tdata   <= in_tdata;
            out_tkeepdw <= in_tkeepdw;
            out_tuser   <= in_tuser;
            out_tlast   <= in_tlast;
            dest        <= eff[1:0];
        end
    end

    assign {out1_tdata, out2_tdata, out3_tdata, out4_tdata} = {4{out_tdata}};
    assign {out1_tkeepdw, out2_tkeepdw, out3_tkeepdw, out4_tkeepdw} = {4{out_tkeepdw}};
    assign {out1_tuser, out2_tuser, out3_tuser, out4_tuser} = {4{out_tuser}};
    assign {out1_tlast, out2_tlast, out3_tlast, out4_tlast} = {4{out_tlast}};
    assign out1_tvalid = out_valid && dest == 2'd0;
    assign out2_tvalid = out_valid && dest == 2'd1;
    assign out3_tvalid = out_valid && dest == 2'd2;
    assign out4_tvalid = out_valid && dest == 2'd3;
    assign out1_has_data = out1_tvalid;
    assign out2_has_data = out2_tvalid;
    assign out3_has_data = out3_tvalid;
    assign out4_has_data = out4_tvalid;
    assign pkt_cnt1 = pkt_cnt[0];
    assign pkt_cnt2 = pkt_cnt[1];
    assign pkt_cnt3 = pkt_cnt[2];
    assign pkt_cnt4 = pkt_cnt[3];
endmodule

// File: tb/tb_pcileech_tlps128_source_demux.sv
// tb_pcileech_tlps128_source_demux: random and directed TLP traffic checked against a packet-level model.
module tb_pcileech_tlps128_source_demux;
    logic clk_pcie = 1'b0;
    logic rst = 1'b1;
    always #5 clk_pcie = ~clk_pcie;

    logic [3:0] port_en = 4'hF;
    logic [127:0] in_tdata = '0;
    logic [3:0] in_tkeepdw = '0;
    logic [8:0] in_tuser = '0;
    logic in_tlast = 1'b0, in_tvalid = 1'b0;
    logic in_tready;
    logic [3:0] rdy = 4'hF;
    logic [3:0][127:0] od;
    logic [3:0][3:0] ok;
    logic [3:0][8:0] ou;
    logic [3:0] ol, ov, hd;
    logic [3:0][15:0] pc;
    logic [15:0] dc;

    pcileech_tlps128_source_demux #(.DROP_OTHER(1'b1), .CNT_WIDTH(16)) dut (
        .clk_pcie(clk_pcie), .rst(rst), .port_en(port_en),
        .in_tdata(in_tdata), .in_tkeepdw(in_tkeepdw), .in_tuser(in_tuser), .in_tlast(in_tlast),
        .in_tvalid(in_tvalid), .in_tready(in_tready),
        .out1_tdata(od[0]), .out1_tkeepdw(ok[0]), .out1_tuser(ou[0]), .out1_tlast(ol[0]),
        .out1_tvalid(ov[0]), .out1_tready(rdy[0]), .out1_has_data(hd[0]),
        .out2_tdata(od[1]), .out2_tkeepdw(ok[1]), .out2_tuser(ou[1]), .out2_tlast(ol[1]),
        .out2_tvalid(ov[1]), .out2_tready(rdy[1]), .out2_has_data(hd[1]),
        .out3_tdata(od[2]), .out3_tkeepdw(ok[2]), .out3_tuser(ou[2]), .out3_tlast(ol[2]),
        .out3_tvalid(ov[2]), .out3_tready(rdy[2]), .out3_has_data(hd[2]),
        .out4_tdata(od[3]), .out4_tkeepdw(ok[3]), .out4_tuser(ou[3]), .out4_tlast(ol[3]),
        .out4_tvalid(ov[3]), .out4_tready(rdy[3]), .out4_has_data(hd[3]),
        .pkt_cnt1(pc[0]), .pkt_cnt2(pc[1]), .pkt_cnt3(pc[2]), .pkt_cnt4(pc[3]), .drop_cnt(dc)
    );

    // Second instance: other TLPs routed to port 4, narrow counters to reach saturation quickly.
    logic [3:0] b_en = 4'hF;
    logic [127:0] b_tdata = '0;
    logic [3:0] b_tkeep = '0;
    logic [8:0] b_tuser = '0;
    logic b_tlast = 1'b0, b_tvalid = 1'b0, b_in_tready;
    logic [3:0][127:0] bod;
    logic [3:0][3:0] bok;
    logic [3:0][8:0] bou;
    logic [3:0] bol, bov, bhd;
    logic [3:0][3:0] bpc;
    logic [3:0] bdc;

    pcileech_tlps128_source_demux #(.DROP_OTHER(1'b0), .CNT_WIDTH(4)) dut_b (
        .clk_pcie(clk_pcie), .rst(rst), .port_en(b_en),
        .in_tdata(b_tdata), .in_tkeepdw(b_tkeep), .in_tuser(b_tuser), .in_tlast(b_tlast),
        .in_tvalid(b_tvalid), .in_tready(b_in_tready),
        .out1_tdata(bod[0]), .out1_tkeepdw(bok[0]), .out1_tuser(bou[0]), .out1_tlast(bol[0]),
        .out1_tvalid(bov[0]), .out1_tready(1'b1), .out1_has_data(bhd[0]),
        .out2_tdata(bod[1]), .out2_tkeepdw(bok[1]), .out2_tuser(bou[1]), .out2_tlast(bol[1]),
        .out2_tvalid(bov[1]), .out2_tready(1'b1), .out2_has_data(bhd[1]),
        .out3_tdata(bod[2]), .out3_tkeepdw(bok[2]), .out3_tuser(bou[2]), .out3_tlast(bol[2]),
        .out3_tvalid(bov[2]), .out3_tready(1'b1), .out3_has_data(bhd[2]),
        .out4_tdata(bod[3]), .out4_tkeepdw(bok[3]), .out4_tuser(bou[3]), .out4_tlast(bol[3]),
        .out4_tvalid(bov[3]), .out4_tready(1'b1), .out4_has_data(bhd[3]),
        .pkt_cnt1(bpc[0]), .pkt_cnt2(bpc[1]), .pkt_cnt3(bpc[2]), .pkt_cnt4(bpc[3]), .drop_cnt(bdc)
    );

    int errs = 0, checks = 0;
    bit rnd_rdy = 1'b0;

    task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
        checks++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    // Packet-level reference: decode fmt/type into a destination (0..3) or 4 for discard.
    typedef struct {
        logic [127:0] d;
        logic [3:0] k;
        logic [8:0] u;
        logic l;
        int p;
    } beat_t;
    beat_t pend[$];
    int m_route = -1;
    logic [15:0] m_pkt [4] = '{default: 16'd0};
    logic [15:0] m_drop = 16'd0;

    function automatic int classify(input logic [127:0] d, input logic [3:0] en);
        logic [2:0] fmt = d[31:29];
        logic [4:0] typ = d[28:24];
        int p;
        if (!fmt[2] && !fmt[0] && typ[4:1] == 4'b0101) p = 0;
        else if (!fmt[2] && !fmt[0] && typ[4:1] == 4'b0010) p = 1;
        else if (!fmt[2] && typ == 5'd0) p = 2;
        else p = 3;
        if (p == 3) return 4;
        return en[p] ? p : 4;
    endfunction

    initial begin
        logic exp_rdy;
        int hp, dst;
        forever begin
            @(negedge clk_pcie);
            hp = pend.size() != 0 ? pend[0].p : 4;
            exp_rdy = hp == 4 || rdy[hp];
            chk("in_tready", in_tready, exp_rdy);
            for (int n = 0; n < 4; n++) begin
                chk($sformatf("out%0d_tvalid", n + 1), ov[n], hp == n);
                chk($sformatf("out%0d_has_data", n + 1), hd[n], hp == n);
                if (hp != 4) begin
                    chk($sformatf("out%0d_tdata", n + 1), od[n], pend[0].d);
                    chk($sformatf("out%0d_tkeepdw", n + 1), ok[n], pend[0].k);
                    chk($sformatf("out%0d_tuser", n + 1), ou[n], pend[0].u);
                    chk($sformatf("out%0d_tlast", n + 1), ol[n], pend[0].l);
                end
                chk($sformatf("pkt_cnt%0d", n + 1), pc[n], m_pkt[n]);
            end
            chk("drop_cnt", dc, m_drop);
            @(posedge clk_pcie);
            if (rst) begin
                pend.delete();
                m_route = -1;
                m_pkt = '{default: 16'd0};
                m_drop = 16'd0;
            end else begin
                if (hp != 4 && rdy[hp]) begin
                    if (pend[0].l && m_pkt[hp] != 16'hFFFF) m_pkt[hp]++;
                    void'(pend.pop_front());
                end
                if (in_tvalid && exp_rdy) begin
                    dst = in_tuser[0] ? classify(in_tdata, port_en) : (m_route < 0 ? 4 : m_route);
                    if (dst == 4) begin
                        if (in_tlast && m_drop != 16'hFFFF) m_drop++;
                    end else
                        pend.push_back('{in_tdata, in_tkeepdw, in_tuser, in_tlast, dst});
                    m_route = in_tlast ? -1 : dst;
                end
            end
        end
    end

    initial forever begin
        @(posedge clk_pcie);
        #1;
        if (rnd_rdy) rdy = 4'($urandom);
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_pcie);
            #1;
        end
    endtask

    task automatic beat(input logic [127:0] d, input logic [8:0] u, input logic l, input logic [3:0] k);
        logic r;
        in_tdata = d; in_tuser = u; in_tlast = l; in_tkeepdw = k; in_tvalid = 1'b1;
        for (int i = 0; ; i++) begin
            @(negedge clk_pcie);
            r = in_tready;
            @(posedge clk_pcie);
            #1;
            if (r) break;
            if (i > 200) begin
                checks++;
                errs++;
                $display("FAIL accept_timeout: got no handshake expected one within 200 cycles");
                break;
            end
        end
        in_tvalid = 1'b0;
    endtask

    task automatic send_pkt(input logic [31:0] hdr, input int len, input bit first, input bit term, input bit rnd);
        for (int b = 0; b < len; b++) begin
            if (rnd && $urandom_range(3) == 0) idle(1);
            if (rnd && $urandom_range(7) == 0) port_en = 4'($urandom);
            beat({$urandom, $urandom, $urandom, b == 0 ? hdr : $urandom},
                 {8'($urandom), first && b == 0}, term && b == len - 1, 4'($urandom));
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    task automatic bbeat(input logic [127:0] d, input logic [8:0] u, input logic l);
        b_tdata = d; b_tuser = u; b_tlast = l; b_tkeep = 4'hF; b_tvalid = 1'b1;
        @(negedge clk_pcie);
        chk("b_in_tready", b_in_tready, 1'b1);
        @(posedge clk_pcie);
        #1;
        b_tvalid = 1'b0;
    endtask

    logic [31:0] hdrs [10] = '{32'h4A000004, 32'h0A000000, 32'h04000001, 32'h44000001, 32'h40000001,
                               32'h00000001, 32'h20000001, 32'h60000001, 32'h34000000, 32'h7C000000};

    initial begin
        idle(3);
        rst = 1'b0;
        // 3-beat CplD to port 1
        beat({96'h1, 32'h4A000004}, 9'h001, 1'b0, 4'hF);
        @(negedge clk_pcie);
        chk("t1_out1_tvalid", ov[0], 1'b1);
        chk("t1_hdr", od[0][31:0], 32'h4A000004);
        chk("t1_other_valid", ov[3:1], 3'b000);
        idle(1);
        send_pkt(32'h4A000004, 2, 1'b0, 1'b1, 1'b0);
        idle(2);
        @(negedge clk_pcie);
        chk("t1_pkt_cnt1", pc[0], 16'd1);
        idle(1);
        // CfgRd then MWr back to back
        do_reset();
        send_pkt(32'h04000001, 1, 1'b1, 1'b1, 1'b0);
        send_pkt(32'h40000001, 2, 1'b1, 1'b1, 1'b0);
        idle(2);
        @(negedge clk_pcie);
        chk("t2_pkt_cnt2", pc[1], 16'd1);
        chk("t2_pkt_cnt3", pc[2], 16'd1);
        idle(1);
        // Msg dropped
        do_reset();
        send_pkt(32'h34000000, 1, 1'b1, 1'b1, 1'b0);
        @(negedge clk_pcie);
        chk("t3_no_valid", ov, 4'b0000);
        chk("t3_drop_cnt", dc, 16'd1);
        idle(1);
        // port 1 stalled for 5 cycles with port 2 traffic queued behind it
        do_reset();
        rdy[0] = 1'b0;
        fork
            begin
                send_pkt(32'h4A000004, 3, 1'b1, 1'b1, 1'b0);
                send_pkt(32'h04000001, 1, 1'b1, 1'b1, 1'b0);
            end
            begin
                repeat (4) @(posedge clk_pcie);
                @(negedge clk_pcie);
                chk("t4_stall_ready", in_tready, 1'b0);
                chk("t4_stall_valid", ov, 4'b0001);
                @(posedge clk_pcie);
                #1;
                rdy[0] = 1'b1;
            end
        join
        idle(2);
        @(negedge clk_pcie);
        chk("t4_pkt_cnt1", pc[0], 16'd1);
        chk("t4_pkt_cnt2", pc[1], 16'd1);
        idle(1);
        // disabled port, then port_en toggled mid-packet
        do_reset();
        port_en = 4'b1110;
        send_pkt(32'h0A000001, 1, 1'b1, 1'b1, 1'b0);
        port_en = 4'hF;
        beat({96'h2, 32'h40000002}, 9'h001, 1'b0, 4'hF);
        port_en = 4'h0;
        send_pkt(32'h0, 2, 1'b0, 1'b1, 1'b0);
        port_en = 4'hF;
        idle(2);
        @(negedge clk_pcie);
        chk("t5_drop_cnt", dc, 16'd1);
        chk("t5_pkt_cnt1", pc[0], 16'd0);
        chk("t5_pkt_cnt3", pc[2], 16'd1);
        idle(1);
        // reset during beat 2 of a 4-beat MWr
        do_reset();
        beat({96'h3, 32'h40000004}, 9'h001, 1'b0, 4'hF);
        in_tdata = 128'h5; in_tuser = 9'h000; in_tlast = 1'b0; in_tvalid = 1'b1; rst = 1'b1;
        @(posedge clk_pcie);
        #1;
        rst = 1'b0;
        in_tvalid = 1'b0;
        @(negedge clk_pcie);
        chk("t6_valid_after_rst", ov, 4'b0000);
        chk("t6_cnt_after_rst", {pc, dc}, '0);
        idle(1);
        send_pkt(32'h6, 2, 1'b0, 1'b1, 1'b0);
        @(negedge clk_pcie);
        chk("t6_orphan_drop", dc, 16'd1);
        idle(1);
        send_pkt(32'h04000001, 1, 1'b1, 1'b1, 1'b0);
        idle(1);
        @(negedge clk_pcie);
        chk("t6_pkt_cnt2", pc[1], 16'd1);
        idle(1);
        // randomized traffic with random backpressure, port_en, orphans and aborts
        rnd_rdy = 1'b1;
        for (int i = 0; i < 300; i++)
            send_pkt($urandom_range(9) == 9 ? $urandom : hdrs[$urandom_range(8)],
                     $urandom_range(1, 4), $urandom_range(15) != 0, $urandom_range(15) != 0, 1'b1);
        rnd_rdy = 1'b0;
        rdy = 4'hF;
        port_en = 4'hF;
        idle(3);
        // DROP_OTHER=0 instance: port 4 delivery and counter saturation
        do_reset();
        bbeat({96'hABC, 32'h34000000}, 9'h1A3, 1'b1);
        @(negedge clk_pcie);
        chk("b_out4_tvalid", bov, 4'b1000);
        chk("b_out4_tdata", bod[3], {96'hABC, 32'h34000000});
        chk("b_out4_tuser", bou[3], 9'h1A3);
        chk("b_out4_tlast", bol[3], 1'b1);
        idle(1);
        bbeat({96'h0, 32'h4A000001}, 9'h001, 1'b1);
        for (int i = 0; i < 20; i++) bbeat({96'(i), 32'h34000000}, 9'h001, 1'b1);
        idle(2);
        @(negedge clk_pcie);
        chk("b_pkt_cnt1", bpc[0], 4'd1);
        chk("b_pkt_cnt4_sat", bpc[3], 4'hF);
        chk("b_drop_cnt0", bdc, 4'd0);
        idle(1);
        b_en = 4'b0111;
        for (int i = 0; i < 20; i++) bbeat({96'(i), 32'h34000000}, 9'h001, 1'b1);
        idle(2);
        @(negedge clk_pcie);
        chk("b_drop_cnt_sat", bdc, 4'hF);
        chk("b_no_valid", bov, 4'b0000);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
